// File: rtl/dev_bridge_pkg.sv
// Shared types and default address map for the dev_bridge_n CPU-to-device bridge.
package dev_bridge_pkg;

    // Bridge transaction states
    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StErr
    } state_e;

    // Largest supported device count; defaults below are sized for it and sliced per instance
    localparam int unsigned MAX_DEV = 8;

    // Wait counter width; covers the full legal timeout range
    localparam int unsigned WAIT_W = 8;

    // Device i base at bits [32i+31:32i]; entries 6 and 7 only matter when N_DEV > 6
    localparam logic [MAX_DEV*32-1:0] DEFAULT_DEV_BASE = {
        32'h0000_7F50, 32'h0000_7F40,
        32'h0000_7F3C, 32'h0000_7F34, 32'h0000_7F2C,
        32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00
    };

    localparam logic [MAX_DEV*32-1:0] DEFAULT_DEV_MASK = {MAX_DEV{32'hFFFF_FFF0}};

    // Address window match for one device
    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/dev_bridge_n_irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dev_bridge_n.sv
// CPU-to-device bridge: decodes a CPU access onto N_DEV one-hot device selects, stalls the
// CPU until the device is ready, and folds synchronised device interrupts onto hwirq.
// Optional feature macro: DEV_BRIDGE_TIMEOUT_EN (bounded device wait, ends in a bus error).
module dev_bridge_n
    import dev_bridge_pkg::*;
#(
    parameter int unsigned         N_DEV    = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE = DEFAULT_DEV_BASE[N_DEV*32-1:0],
    parameter logic [N_DEV*32-1:0] DEV_MASK = DEFAULT_DEV_MASK[N_DEV*32-1:0],
    parameter int unsigned         TIMEOUT  = 15,
    parameter int unsigned         IRQ_W    = 6
) (
    input  logic                  clk,
    input  logic                  sys_rstn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_be,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stop,
    output logic                  cpu_err,
    output logic [N_DEV-1:0]      dev_sel,
    output logic                  dev_we,
    output logic [3:0]            dev_be,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wdata,
    input  logic [N_DEV*32-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]      dev_ready,
    input  logic [N_DEV-1:0]      dev_irq,
    output logic [IRQ_W-1:0]      hwirq
);

    localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             hit_any;
    logic [IDX_W-1:0] hit_idx;
    logic [31:0]      sel_rdata;
    logic             sel_ready;
    logic             timed_out;

    logic [N_DEV-1:0] irq_s;
    logic [IRQ_W-1:0] hwirq_q, hwirq_d;

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = int'(N_DEV) - 1; i >= 0; i--) begin
            if (addr_hit(cpu_addr, DEV_BASE[i*32 +: 32], DEV_MASK[i*32 +: 32])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sel_rdata = dev_rdata[idx_q*32 +: 32];
    assign sel_ready = dev_ready[idx_q];

`ifdef DEV_BRIDGE_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Wait counter runs only while a device access is pending
    always_comb begin
        wait_d = '0;
        if (state_q == StAccess && !sel_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // This cycle's miss is the TIMEOUT-th consecutive one
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // Next-state and request latching
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    if (hit_any) begin
                        state_d = StAccess;
                        idx_d   = hit_idx;
                        we_d    = cpu_we;
                        be_d    = cpu_be;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        state_d = StErr;
                        if (!cpu_we) rdata_d = '0;
                    end
                end
            end
            StAccess: begin
                if (sel_ready) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = sel_rdata;
                end else if (timed_out) begin
                    state_d = StErr;
                    if (!we_q) rdata_d = '0;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM and request latches
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // State-decoded CPU handshake and device strobes; strobes fall with reset immediately
    always_comb begin
        cpu_stop = 1'b0;
        cpu_err  = 1'b0;
        dev_sel  = '0;
        dev_we   = 1'b0;
        unique case (state_q)
            StIdle: cpu_stop = cpu_req;
            StAccess: begin
                cpu_stop = 1'b1;
                dev_we   = we_q;
                for (int i = 0; i < int'(N_DEV); i++) begin
                    dev_sel[i] = (idx_q == IDX_W'(i));
                end
            end
            StErr:   cpu_err = 1'b1;
            default: ;
        endcase
    end

    assign cpu_rdata = rdata_q;
    assign dev_be    = be_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;

    for (genvar g = 0; g < int'(N_DEV); g++) begin : g_irq_sync
        irq_sync u_irq_sync (
            .clk   (clk),
            .rst_n (sys_rstn),
            .d     (dev_irq[g]),
            .q     (irq_s[g])
        );
    end

    // Fold synchronised lines onto hwirq modulo IRQ_W
    always_comb begin
        hwirq_d = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            hwirq_d[i % int'(IRQ_W)] = hwirq_d[i % int'(IRQ_W)] | irq_s[i];
        end
    end

    // Registered interrupt outputs
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            hwirq_q <= '0;
        end else begin
            hwirq_q <= hwirq_d;
        end
    end

    assign hwirq = hwirq_q;

endmodule

// File: tb/tb_dev_bridge_n.sv
// Directed self-checking bench for dev_bridge_n (default 6-device instance plus an 8-device
// instance with overlapping windows for priority and interrupt folding).
module tb_dev_bridge_n;

    logic         clk = 1'b0;
    logic         sys_rstn;

    logic         cpu_req, cpu_we;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_stop, cpu_err;
    logic [5:0]   dev_sel;
    logic         dev_we;
    logic [3:0]   dev_be;
    logic [31:0]  dev_addr, dev_wdata;
    logic [191:0] dev_rdata;
    logic [5:0]   dev_ready, dev_irq, hwirq;

    logic         cpu_req8, cpu_we8;
    logic [3:0]   cpu_be8;
    logic [31:0]  cpu_addr8, cpu_wdata8, cpu_rdata8;
    logic         cpu_stop8, cpu_err8;
    logic [7:0]   dev_sel8;
    logic         dev_we8;
    logic [3:0]   dev_be8;
    logic [31:0]  dev_addr8, dev_wdata8;
    logic [255:0] dev_rdata8;
    logic [7:0]   dev_ready8, dev_irq8;
    logic [5:0]   hwirq8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dev_bridge_n dut (
        .clk(clk), .sys_rstn(sys_rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stop(cpu_stop), .cpu_err(cpu_err),
        .dev_sel(dev_sel), .dev_we(dev_we), .dev_be(dev_be), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ready(dev_ready),
        .dev_irq(dev_irq), .hwirq(hwirq)
    );

    // Device 0 window covers 0x8000-0x8FFF and overlaps device 3 at 0x8010
    dev_bridge_n #(
        .N_DEV    (8),
        .DEV_BASE ({32'h9070, 32'h9060, 32'h9050, 32'h9040,
                    32'h8010, 32'h9020, 32'h9010, 32'h8000}),
        .DEV_MASK ({{7{32'hFFFF_FFF0}}, 32'hFFFF_F000})
    ) dut8 (
        .clk(clk), .sys_rstn(sys_rstn),
        .cpu_req(cpu_req8), .cpu_we(cpu_we8), .cpu_be(cpu_be8), .cpu_addr(cpu_addr8),
        .cpu_wdata(cpu_wdata8), .cpu_rdata(cpu_rdata8), .cpu_stop(cpu_stop8),
        .cpu_err(cpu_err8), .dev_sel(dev_sel8), .dev_we(dev_we8), .dev_be(dev_be8),
        .dev_addr(dev_addr8), .dev_wdata(dev_wdata8), .dev_rdata(dev_rdata8),
        .dev_ready(dev_ready8), .dev_irq(dev_irq8), .hwirq(hwirq8)
    );

    task automatic test_reset;
        sys_rstn = 1'b0;
        dev_irq  = 6'h3F;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++;
            $display("FAIL reset_rdata: got %h, expected %h", cpu_rdata, 32'h0); end
        n_checks++; if (dev_sel !== 6'b0 || dev_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_strobes: got sel=%b we=%b, expected 0", dev_sel, dev_we); end
        n_checks++; if (cpu_err !== 1'b0 || cpu_stop !== 1'b0) begin n_fail++;
            $display("FAIL reset_cpu: got err=%b stop=%b, expected 0", cpu_err, cpu_stop); end
        n_checks++; if (hwirq !== 6'b0) begin n_fail++;
            $display("FAIL reset_hwirq: got %b, expected 0", hwirq); end
        dev_irq = 6'h0;
        @(negedge clk);
        sys_rstn = 1'b1;
    endtask

    // Read from device 2 which is ready only on the 4th access cycle
    task automatic test_read_wait;
        int stops = 0;
        @(negedge clk);
        dev_rdata[95:64] = 32'hCAFE_0001;
        dev_rdata[63:32] = 32'h1111_1111;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h7F24;
        for (int c = 0; c < 6; c++) begin
            dev_ready = (c == 4) ? 6'b000100 : 6'b0;
            if (c == 5) cpu_req = 1'b0;
            #1;
            stops += int'(cpu_stop);
            if (c == 1) begin
                n_checks++; if (dev_sel !== 6'b000100 || dev_we !== 1'b0) begin n_fail++;
                    $display("FAIL read_sel: got sel=%b we=%b, expected 000100 0", dev_sel, dev_we); end
                n_checks++; if (dev_addr !== 32'h7F24) begin n_fail++;
                    $display("FAIL read_addr: got %h, expected %h", dev_addr, 32'h7F24); end
            end
            if (c == 5) begin
                n_checks++; if (cpu_rdata !== 32'hCAFE_0001 || cpu_stop !== 1'b0) begin n_fail++;
                    $display("FAIL read_done: got rdata=%h stop=%b, expected cafe0001 0",
                             cpu_rdata, cpu_stop); end
                n_checks++; if (dev_sel !== 6'b0) begin n_fail++;
                    $display("FAIL read_done_sel: got %b, expected 0", dev_sel); end
            end
            @(negedge clk);
        end
        n_checks++; if (stops != 5) begin n_fail++;
            $display("FAIL read_stop_cycles: got %0d, expected 5", stops); end
    endtask

    // Zero-wait write to device 1
    task automatic test_write;
        int stops = 0;
        int sels  = 0;
        int wes   = 0;
        dev_ready = 6'b000010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF;
        cpu_addr = 32'h7F10; cpu_wdata = 32'h1234_5678;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) cpu_req = 1'b0;
            #1;
            stops += int'(cpu_stop);
            sels  += int'(dev_sel == 6'b000010);
            wes   += int'(dev_we);
            if (c == 1) begin
                n_checks++; if (dev_wdata !== 32'h1234_5678 || dev_be !== 4'hF) begin n_fail++;
                    $display("FAIL write_data: got %h be=%h, expected 12345678 f", dev_wdata, dev_be); end
            end
            if (c == 2) begin
                n_checks++; if (cpu_rdata !== 32'hCAFE_0001) begin n_fail++;
                    $display("FAIL write_keeps_rdata: got %h, expected cafe0001", cpu_rdata); end
            end
            @(negedge clk);
        end
        n_checks++; if (stops != 2) begin n_fail++;
            $display("FAIL write_stop_cycles: got %0d, expected 2", stops); end
        n_checks++; if (sels != 1 || wes != 1) begin n_fail++;
            $display("FAIL write_strobes: got sel=%0d we=%0d cycles, expected 1 1", sels, wes); end
    endtask

    task automatic test_unmapped;
        dev_ready = 6'h3F;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000;
        #1;
        n_checks++; if (cpu_stop !== 1'b1 || cpu_err !== 1'b0) begin n_fail++;
            $display("FAIL unmapped_req: got stop=%b err=%b, expected 1 0", cpu_stop, cpu_err); end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        n_checks++; if (cpu_err !== 1'b1 || cpu_stop !== 1'b0 || dev_sel !== 6'b0) begin n_fail++;
            $display("FAIL unmapped_err: got err=%b stop=%b sel=%b, expected 1 0 0",
                     cpu_err, cpu_stop, dev_sel); end
        n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++;
            $display("FAIL unmapped_rdata: got %h, expected 0", cpu_rdata); end
        @(negedge clk);
        #1;
        n_checks++; if (cpu_err !== 1'b0) begin n_fail++;
            $display("FAIL unmapped_err_pulse: got %b, expected 0", cpu_err); end
    endtask

    task automatic test_irq;
        dev_irq  = 6'b010000;
        dev_irq8 = 8'b1100_0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if (hwirq !== ((c == 3) ? 6'b010000 : 6'b0)) begin n_fail++;
                $display("FAIL irq_latency_c%0d: got %b", c, hwirq); end
        end
        n_checks++; if (hwirq8 !== 6'b000011) begin n_fail++;
            $display("FAIL irq_fold: got %b, expected 000011", hwirq8); end
        dev_irq  = 6'b0;
        dev_irq8 = 8'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (hwirq !== 6'b0 || hwirq8 !== 6'b0) begin n_fail++;
            $display("FAIL irq_clear: got %b %b, expected 0 0", hwirq, hwirq8); end
    endtask

    // Address 0x8010 hits devices 0 and 3 on the 8-device instance
    task automatic test_priority;
        @(negedge clk);
        dev_rdata8[31:0]   = 32'hD0D0_0000;
        dev_rdata8[127:96] = 32'hD3D3_0000;
        dev_ready8 = 8'b0000_1001;
        cpu_req8 = 1'b1; cpu_we8 = 1'b0; cpu_be8 = 4'hF; cpu_addr8 = 32'h8010;
        @(negedge clk);
        #1;
        n_checks++; if (dev_sel8 !== 8'b0000_0001) begin n_fail++;
            $display("FAIL priority_sel: got %b, expected 00000001", dev_sel8); end
        @(negedge clk);
        cpu_req8 = 1'b0;
        #1;
        n_checks++; if (cpu_rdata8 !== 32'hD0D0_0000) begin n_fail++;
            $display("FAIL priority_rdata: got %h, expected d0d00000", cpu_rdata8); end
    endtask

    task automatic test_reset_mid;
        int act = 0;
        @(negedge clk);
        dev_ready = 6'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F10; cpu_wdata = 32'hAA;
        @(negedge clk);
        #1;
        n_checks++; if (dev_sel !== 6'b000010 || dev_we !== 1'b1) begin n_fail++;
            $display("FAIL midreset_access: got sel=%b we=%b, expected 000010 1", dev_sel, dev_we); end
        #1;
        sys_rstn = 1'b0;
        cpu_req  = 1'b0;
        #1;
        n_checks++; if (dev_sel !== 6'b0 || dev_we !== 1'b0) begin n_fail++;
            $display("FAIL midreset_drop: got sel=%b we=%b, expected 0 0", dev_sel, dev_we); end
        @(negedge clk);
        sys_rstn = 1'b1;
        dev_ready = 6'h3F;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (dev_sel !== 6'b0 || dev_we !== 1'b0 || cpu_stop !== 1'b0) act++;
        end
        n_checks++; if (act != 0) begin n_fail++;
            $display("FAIL midreset_quiet: got %0d active cycles, expected 0", act); end
    endtask

    // Device 0 never ready: bounded by timeout when enabled, otherwise stalls indefinitely
    task automatic test_timeout;
        int err_cycle = 0;
        @(negedge clk);
        dev_ready = 6'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F00;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (cpu_err === 1'b1 && err_cycle == 0) begin
                err_cycle = c;
                cpu_req = 1'b0;
            end
            @(negedge clk);
        end
`ifdef DEV_BRIDGE_TIMEOUT_EN
        n_checks++; if (err_cycle != 17) begin n_fail++;
            $display("FAIL timeout_cycle: got %0d, expected 17", err_cycle); end
        #1;
        n_checks++; if (cpu_stop !== 1'b0 || dev_sel !== 6'b0) begin n_fail++;
            $display("FAIL timeout_idle: got stop=%b sel=%b, expected 0 0", cpu_stop, dev_sel); end
`else
        n_checks++; if (err_cycle != 0) begin n_fail++;
            $display("FAIL wait_no_err: got err on cycle %0d, expected none", err_cycle); end
        #1;
        n_checks++; if (cpu_stop !== 1'b1 || dev_sel !== 6'b000001) begin n_fail++;
            $display("FAIL wait_stall: got stop=%b sel=%b, expected 1 000001", cpu_stop, dev_sel); end
        dev_ready = 6'b000001;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (cpu_stop !== 1'b0 || dev_sel !== 6'b0) begin n_fail++;
            $display("FAIL wait_release: got stop=%b sel=%b, expected 0 0", cpu_stop, dev_sel); end
`endif
    endtask

    initial begin
        sys_rstn = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        dev_rdata = '0; dev_ready = '0; dev_irq = '0;
        cpu_req8 = 1'b0; cpu_we8 = 1'b0; cpu_be8 = 4'h0; cpu_addr8 = '0; cpu_wdata8 = '0;
        dev_rdata8 = '0; dev_ready8 = '0; dev_irq8 = '0;

        test_reset;
        test_read_wait;
        test_write;
        test_unmapped;
        test_irq;
        test_priority;
        test_reset_mid;
        test_timeout;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_bridge_n.md
DEV_BRIDGE_N -- requirements
Module: dev_bridge_n

Interface
REQ-001 SHALL have parameter N_DEV, default 6: number of device ports, legal 1..8.
REQ-002 SHALL have parameter DEV_BASE, default {0x7F00,0x7F10,0x7F20,0x7F2C,0x7F34,0x7F3C} (N_DEV x 32 packed): device i base address.
REQ-003 SHALL have parameter DEV_MASK, default 0xFFFFFFF0 per device (N_DEV x 32 packed): device i hits when (cpu_addr & mask_i) == base_i.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum wait cycles per access, legal 1..255.
REQ-005 SHALL have parameter IRQ_W, default 6: hwirq width.
REQ-006 SHALL have ports: clk in 1 (system clock); sys_rstn in 1 (asynchronous, active-low reset).
REQ-007 SHALL have ports: cpu_req in 1 (access request); cpu_we in 1 (write); cpu_be in 4 (byte enables); cpu_addr in 32; cpu_wdata in 32.
REQ-008 SHALL have ports: cpu_rdata out 32 (read data); cpu_stop out 1 (stall CPU); cpu_err out 1 (bus error, one-cycle pulse).
REQ-009 SHALL have ports: dev_sel out N_DEV (one-hot select); dev_we out 1; dev_be out 4; dev_addr out 32; dev_wdata out 32.
REQ-010 SHALL have ports: dev_rdata in N_DEV*32 (device i data at bits [32i+31:32i]); dev_ready in N_DEV (access complete); dev_irq in N_DEV (level interrupt).
REQ-011 SHALL have port: hwirq out IRQ_W (synchronised interrupt lines).

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-013 IDLE with cpu_req=1: decoded hit -> ACCESS and latch addr/we/be/wdata/index; no hit -> ERR.
REQ-014 Multiple hits SHALL resolve to the lowest device index.
REQ-015 ACCESS: dev_sel one-hot to latched index; dev_we/dev_be/dev_addr/dev_wdata driven from latches; all other cycles dev_sel=0 and dev_we=0.
REQ-016 ACCESS with dev_ready[index]=1 -> DONE, capturing that device's dev_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged).
REQ-017 ACCESS with dev_ready[index]=0 SHALL increment the wait counter and remain in ACCESS.
REQ-018 DONE -> IDLE unconditionally; ERR -> IDLE unconditionally, asserting cpu_err for that cycle.
REQ-019 cpu_stop SHALL be 1 in IDLE while cpu_req=1, and in ACCESS; it SHALL be 0 in IDLE with cpu_req=0, in DONE and in ERR.
REQ-020 Latency: a zero-wait device completes in 3 cycles (cpu_stop high for 2).
REQ-021 CPU SHALL hold its request stable while cpu_stop=1; inputs are sampled only in IDLE.
REQ-022 Each dev_irq SHALL pass through a 2-flop synchroniser; hwirq[k] SHALL be the registered OR of synchronised dev_irq[i] over all i with i mod IRQ_W == k.
REQ-023 Unmapped reads that end in ERR SHALL set cpu_rdata to 0.

Reset
REQ-024 sys_rstn=0 SHALL asynchronously force: state IDLE, cpu_rdata 0, cpu_err 0, dev_sel 0, dev_we 0, wait counter 0, synchroniser flops 0, hwirq 0.
REQ-025 Reset asserted mid-access SHALL abort it; no dev_sel or dev_we pulse SHALL follow release.

Configuration
REQ-026 With macro DEV_BRIDGE_TIMEOUT_EN defined, ACCESS SHALL enter ERR when the wait counter reaches TIMEOUT without ready; dev_sel SHALL drop in the ERR cycle.
REQ-027 Without DEV_BRIDGE_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter SHALL be synthesised.

Structure
REQ-028 Package dev_bridge_pkg SHALL hold the FSM state enum and the default base/mask constants.
REQ-029 Sub-module irq_sync SHALL implement the per-line 2-flop synchroniser and be instantiated N_DEV times.

Verification
REQ-030 Write of 0x12345678 to 0x7F10 (device 1, ready tied high): dev_sel=0b000010 for one cycle, dev_we=1, cpu_stop high 2 cycles.
REQ-031 Read of 0x7F24 with device 2 ready after 3 waits, returning 0xCAFE0001: cpu_rdata=0xCAFE0001 in DONE, cpu_stop high 5 cycles.
REQ-032 Read of 0x00001000 (unmapped): ERR after 1 cycle, cpu_err pulse, cpu_rdata=0, no dev_sel.
REQ-033 DEV_BRIDGE_TIMEOUT_EN defined, TIMEOUT=15, device 0 never ready: cpu_err on cycle 17 after request, then IDLE.
REQ-034 dev_irq[4] rises: hwirq[4]=1 exactly 3 cycles later; with N_DEV=8, dev_irq[6] drives hwirq[0].
REQ-035 sys_rstn pulled low during ACCESS: dev_sel=0 immediately; after release, state IDLE and no bus activity until a new cpu_req.
